// File: rtl/demux_dispatcher.sv
// demux_dispatcher: one-entry registered dispatch stage feeding a 4-way demux.
// A word accepted from the source is held and presented to exactly one of four
// consumers, chosen round-robin (mode=0) or by in_dest (mode=1).
// Optional per-channel delivery counters are built when DISPATCH_STATS_EN is defined.
module demux_dispatcher #(
  parameter int unsigned N = 32
`ifdef DISPATCH_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic [N-1:0] in_data,
  input  logic [1:0]   in_dest,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [1:0]   dmx_c,
  output logic [N-1:0] dmx_in,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic         busy
`ifdef DISPATCH_STATS_EN
  , input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`endif
);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t     state;
  logic [1:0] rr_ptr;
  logic [1:0] dest;
  logic       accept;
  logic       deliver;

  // Handshake decode; in_ready depends only on state and the selected consumer ready
  assign busy     = (state == HOLD);
  assign deliver  = busy & out_ready[dmx_c];
  assign in_ready = ~busy | out_ready[dmx_c];
  assign accept   = in_valid & in_ready;
  assign dest     = mode ? in_dest : rr_ptr;

  // Dispatch FSM: accept (possibly together with a delivery) loads the stage, a bare delivery empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      dmx_c     <= 2'b00;
      dmx_in    <= '0;
      out_valid <= 4'b0000;
      rr_ptr    <= 2'b00;
    end else begin
      case (state)
        EMPTY, HOLD: begin
          if (accept) begin
            state     <= HOLD;
            dmx_c     <= dest;
            dmx_in    <= in_data;
            out_valid <= 4'b0001 << dest;
            if (!mode) rr_ptr <= rr_ptr + 2'd1;
          end else if (deliver) begin
            state     <= EMPTY;
            dmx_in    <= '0;
            out_valid <= 4'b0000;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0] cnt_q [4];

  // Saturating per-channel delivery counters; clear wins over an increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (stats_clr) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (deliver && (cnt_q[dmx_c] != {CNT_W{1'b1}})) begin
      cnt_q[dmx_c] <= cnt_q[dmx_c] + CNT_W'(1);
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_dispatcher.sv
// tb_demux_dispatcher: directed self-checking bench with a delivery scoreboard.
// Build with DISPATCH_STATS_EN defined to also exercise the counters (CNT_W=4).
module tb_demux_dispatcher;

  localparam int unsigned N = 32;

  typedef struct packed {
    logic [1:0]   dest;
    logic [N-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode;
  logic [N-1:0] in_data;
  logic [1:0]   in_dest;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   dmx_c;
  logic [N-1:0] dmx_in;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic         busy;
`ifdef DISPATCH_STATS_EN
  logic         stats_clr;
  logic [3:0]   cnt0, cnt1, cnt2, cnt3;
`endif

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  int   rr = 0;

  always #5 clk = ~clk;

  demux_dispatcher #(
    .N(N)
`ifdef DISPATCH_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dmx_c    (dmx_c),
    .dmx_in   (dmx_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
`ifdef DISPATCH_STATS_EN
    , .stats_clr(stats_clr),
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt2     (cnt2),
    .cnt3     (cnt3)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one word that the bench knows will be accepted at the next edge; record where it must go
  task automatic send(input logic [N-1:0] d, input logic m, input logic [1:0] ddest);
    exp_t e;
    mode     = m;
    in_data  = d;
    in_dest  = ddest;
    in_valid = 1'b1;
    e.data   = d;
    e.dest   = m ? ddest : 2'(rr);
    if (!m) rr = (rr + 1) % 4;
    sb.push_back(e);
  endtask

  // Scoreboard: a delivery happens at the next edge when the held word's consumer is ready
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && busy === 1'b1 && out_ready[dmx_c] === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_delivery", 64'(dmx_in), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("sb_dmx_c", 64'(dmx_c), 64'(e.dest));
        check("sb_dmx_in", 64'(dmx_in), 64'(e.data));
        check("sb_out_valid", 64'(out_valid), 64'(4'b0001 << e.dest));
      end
    end
  end

  initial begin
    logic [N-1:0] words [5];
    words[0] = 32'hA0A0_0001; words[1] = 32'hB0B0_0002; words[2] = 32'hC0C0_0003;
    words[3] = 32'hD0D0_0004; words[4] = 32'hE0E0_0005;

    rst_n = 1'b0; mode = 1'b0; in_data = '0; in_dest = 2'd0; in_valid = 1'b0; out_ready = 4'b0000;
`ifdef DISPATCH_STATS_EN
    stats_clr = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_in_ready", 64'(in_ready), 64'h1);
    check("reset_dmx_c", 64'(dmx_c), 64'h0);
    check("reset_dmx_in", 64'(dmx_in), 64'h0);

    // Round-robin streaming, one word per clock
    out_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      send(words[i], 1'b0, 2'd0);
      tick();
      check("rr_out_valid", 64'(out_valid), 64'(4'b0001 << (i % 4)));
      check("rr_dmx_c", 64'(dmx_c), 64'(i % 4));
      check("rr_in_ready", 64'(in_ready), 64'h1);
    end
    in_valid = 1'b0;
    tick();
    check("rr_drain_busy", 64'(busy), 64'h0);
    check("rr_drain_out_valid", 64'(out_valid), 64'h0);
    check("rr_drain_dmx_in", 64'(dmx_in), 64'h0);
    check("rr_drain_dmx_c_kept", 64'(dmx_c), 64'h0);

    // Directed word to channel 2 with its consumer stalled
    out_ready = 4'b1011;
    send(32'h0000_1234, 1'b1, 2'd2);
    tick();
    in_data = 32'h0000_BEEF; in_dest = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", 64'(in_ready), 64'h0);
      check("stall_out_valid", 64'(out_valid), 64'h4);
      check("stall_dmx_in", 64'(dmx_in), 64'h1234);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 4'b1111;
    #1;
    check("stall_release_in_ready", 64'(in_ready), 64'h1);
    tick();
    check("stall_done_busy", 64'(busy), 64'h0);
    check("stall_done_dmx_c_kept", 64'(dmx_c), 64'h2);

    // Held for channel 1 while only other channels are ready
    out_ready = 4'b0000;
    send(32'h0000_0055, 1'b0, 2'd0);
    tick();
    in_data = 32'h0000_0066; in_valid = 1'b1; mode = 1'b0;
    out_ready = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("wrong_ready_in_ready", 64'(in_ready), 64'h0);
      check("wrong_ready_out_valid", 64'(out_valid), 64'h2);
      check("wrong_ready_dmx_in", 64'(dmx_in), 64'h55);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 4'b0010;
    tick();
    check("wrong_ready_done_busy", 64'(busy), 64'h0);

    // Pointer untouched by the stall: next round-robin words land on 2 then 3
    out_ready = 4'b1111;
    send(32'h0000_0200, 1'b0, 2'd0);
    tick();
    check("rr_resume_dmx_c", 64'(dmx_c), 64'h2);
    send(32'h0000_0300, 1'b0, 2'd0);
    tick();
    check("rr_resume2_dmx_c", 64'(dmx_c), 64'h3);

    // Mixed modes: RR (ptr 0->1), directed to 3, RR again to 1
    send(32'h0000_0A00, 1'b0, 2'd2);
    tick();
    check("mixed_rr0_dmx_c", 64'(dmx_c), 64'h0);
    send(32'h0000_0A03, 1'b1, 2'd3);
    tick();
    check("mixed_dir3_dmx_c", 64'(dmx_c), 64'h3);
    send(32'h0000_0A01, 1'b0, 2'd0);
    tick();
    check("mixed_rr1_dmx_c", 64'(dmx_c), 64'h1);
    in_valid = 1'b0;
    tick();

    // mode changing while holding does not move the held word
    out_ready = 4'b0000;
    send(32'h0000_0C02, 1'b0, 2'd0);
    tick();
    in_valid = 1'b0; mode = 1'b1; in_dest = 2'd0;
    tick();
    check("mode_change_dmx_c", 64'(dmx_c), 64'h2);
    check("mode_change_out_valid", 64'(out_valid), 64'h4);
    out_ready = 4'b0100;
    tick();

    // Reset while holding drops the word immediately
    out_ready = 4'b0000;
    send(32'h0000_0077, 1'b1, 2'd1);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    void'(sb.pop_back());
    rr = 0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'h0);
    check("midreset_busy", 64'(busy), 64'h0);
    check("midreset_in_ready", 64'(in_ready), 64'h1);
    check("midreset_dmx_in", 64'(dmx_in), 64'h0);
    tick();
    rst_n = 1'b1;
    out_ready = 4'b1111;
    tick();
    check("postreset_busy", 64'(busy), 64'h0);
    send(32'h0000_0E00, 1'b0, 2'd3);
    tick();
    check("postreset_rr_dmx_c", 64'(dmx_c), 64'h0);
    in_valid = 1'b0;
    tick();

`ifdef DISPATCH_STATS_EN
    // Saturating counter and clear-over-increment
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("stats_clr_cnt0", 64'(cnt0), 64'h0);
    for (int i = 0; i < 17; i++) begin
      send(32'h0000_5000 + 32'(i), 1'b1, 2'd0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("stats_sat_cnt0", 64'(cnt0), 64'hF);
    check("stats_cnt1_idle", 64'(cnt1), 64'h0);
    send(32'h0000_6000, 1'b1, 2'd0);
    tick();
    in_valid = 1'b0;
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("stats_clr_priority_cnt0", 64'(cnt0), 64'h0);
    check("stats_clr_priority_busy", 64'(busy), 64'h0);
`endif

    tick();
    check("sb_empty_at_end", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
